// File: rtl/dmem_pkg.sv
// Shared types and RV32I load/store helpers for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] lo);
    logic [3:0] m;
    case (funct3)
      F3_B, F3_BU: m = 4'b0001 << lo;
      F3_H, F3_HU: m = lo[1] ? 4'b1100 : 4'b0011;
      F3_W:        m = 4'b1111;
      default:     m = 4'b0000;
    endcase
    return m;
  endfunction

  // Replicate right-aligned store data so every enabled lane sees its bytes.
  function automatic logic [31:0] store_align(input logic [2:0] funct3, input logic [31:0] wdata);
    logic [31:0] d;
    case (funct3)
      F3_B:    d = {4{wdata[7:0]}};
      F3_H:    d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] funct3,
                                              input logic [1:0] lo);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_BU:   r = {24'd0, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_HU:   r = {16'd0, h};
      F3_W:    r = word;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic access_err(input logic rd, input logic wr, input logic [2:0] funct3,
                                      input logic [1:0] lo);
    logic e;
    if (rd && wr) begin
      e = 1'b1;
    end else if (wr) begin
      case (funct3)
        F3_B:    e = 1'b0;
        F3_H:    e = lo[0];
        F3_W:    e = (lo != 2'b00);
        default: e = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_B, F3_BU: e = 1'b0;
        F3_H, F3_HU: e = lo[0];
        F3_W:        e = (lo != 2'b00);
        default:     e = 1'b1;
      endcase
    end
    return e;
  endfunction

endpackage

// File: rtl/dmem_bram.sv
// Byte-enabled single-port word RAM with synchronous write and registered read.
module dmem_bram #(
  parameter int WORD_AW = 7
) (
  input  logic               clk,
  input  logic               en,
  input  logic [3:0]         we,
  input  logic [WORD_AW-1:0] addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata
);

  logic [3:0][7:0] mem [2**WORD_AW] = '{default: 32'd0};
  logic [31:0]     rdata_q;

  // Read-before-write port: only touched when the responder commits.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          mem[addr][i] <= wdata[8*i +: 8];
        end
      end
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: captures one request, waits WAIT_CYCLES, commits to RAM,
// then pulses ready with the extended load data and an access-error flag.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              ready,
  output logic              err
);

  localparam int         WORD_AW   = ADDR_W - 2;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        f3_q, f3_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rd_q, rd_d, wr_q, wr_d;
  logic              ready_q, ready_d, err_q, err_d, ld_q, ld_d;

  logic [ADDR_W-1:0] op_addr_s;
  logic [2:0]        op_f3_s;
  logic [DATA_W-1:0] op_wdata_s;
  logic              op_rd_s, op_wr_s, acc_err_s, commit_s;
  logic [3:0]        ram_we_s;
  logic [31:0]       ram_rdata_s;

  // With zero wait states the commit uses the live inputs in the capture cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    f3_d       = f3_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    commit_s   = 1'b0;
    op_addr_s  = addr_q;
    op_f3_s    = f3_q;
    op_wdata_s = wdata_q;
    op_rd_s    = rd_q;
    op_wr_s    = wr_q;
    case (state_q)
      IDLE: begin
        op_addr_s  = addr;
        op_f3_s    = funct3;
        op_wdata_s = wr_data;
        op_rd_s    = rd;
        op_wr_s    = wr;
        if (rd | wr) begin
          addr_d  = addr;
          f3_d    = funct3;
          wdata_d = wr_data;
          rd_d    = rd;
          wr_d    = wr;
          if (WAIT_CYCLES == 0) begin
            commit_s = 1'b1;
            state_d  = DONE;
          end else begin
            cnt_d   = WAIT_LOAD;
            state_d = BUSY;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          commit_s = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    acc_err_s = access_err(op_rd_s, op_wr_s, op_f3_s, op_addr_s[1:0]);
    if (commit_s) begin
      ready_d = 1'b1;
      err_d   = acc_err_s;
      ld_d    = op_rd_s & ~acc_err_s;
    end else begin
      ready_d = 1'b0;
      err_d   = 1'b0;
      ld_d    = 1'b0;
    end
    if (commit_s && op_wr_s && !acc_err_s) begin
      ram_we_s = lane_mask(op_f3_s, op_addr_s[1:0]);
    end else begin
      ram_we_s = 4'b0000;
    end
  end

  // State, captured request and output flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= {ADDR_W{1'b0}};
      f3_q    <= 3'b000;
      wdata_q <= {DATA_W{1'b0}};
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      ld_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      ld_q    <= ld_d;
    end
  end

  // Reset on the commit edge suppresses the RAM write.
  dmem_bram #(.WORD_AW(WORD_AW)) u_bram (
    .clk   (clk),
    .en    (commit_s & ~reset),
    .we    (ram_we_s),
    .addr  (op_addr_s[ADDR_W-1:2]),
    .wdata (store_align(op_f3_s, op_wdata_s)),
    .rdata (ram_rdata_s)
  );

  assign ready   = ready_q;
  assign err     = err_q;
  assign rd_data = ld_q ? load_extend(ram_rdata_s, f3_q, addr_q[1:0]) : {DATA_W{1'b0}};

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance
// checked against a byte-array memory model.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_s, rd_s, wr_s;
  logic [1:0][8:0]  addr_s;
  logic [1:0][2:0]  f3_s;
  logic [1:0][31:0] wdata_s;
  logic             ready_w2, ready_w0, err_w2, err_w0;
  logic [31:0]      rdata_w2, rdata_w0;

  dmem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .reset(rst_s[0]), .wr(wr_s[0]), .rd(rd_s[0]), .addr(addr_s[0]),
    .funct3(f3_s[0]), .wr_data(wdata_s[0]), .rd_data(rdata_w2), .ready(ready_w2), .err(err_w2)
  );

  dmem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .reset(rst_s[1]), .wr(wr_s[1]), .rd(rd_s[1]), .addr(addr_s[1]),
    .funct3(f3_s[1]), .wr_data(wdata_s[1]), .rd_data(rdata_w0), .ready(ready_w0), .err(err_w0)
  );

  typedef struct {
    int          dut;
    logic        err;
    logic [31:0] data;
    int          req_cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mdl [2][512];
  int         wait_of[2] = '{2, 0};
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic       mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic ready_of(input int d);
    return (d == 0) ? ready_w2 : ready_w0;
  endfunction

  // Reference: little-endian byte memory, RV32I size/sign rules, error checks.
  task automatic model(input int d, input logic r, input logic w, input logic [8:0] a,
                       input logic [2:0] f, input logic [31:0] wd,
                       output logic e, output logic [31:0] q);
    int n, base, ai;
    logic [31:0] v;
    ai = int'(a);
    n  = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
    e  = 1'b0;
    if (r && w) e = 1'b1;
    if (f[1:0] == 2'd3) e = 1'b1;
    if (w && f[2]) e = 1'b1;
    if (r && f == 3'b110) e = 1'b1;
    if (ai % n != 0) e = 1'b1;
    base = ai - (ai % n);
    q = 32'd0;
    if (!e && w) begin
      for (int i = 0; i < n; i++) mdl[d][base + i] = wd[8*i +: 8];
    end
    if (!e && r) begin
      v = 32'd0;
      for (int i = 0; i < n; i++) v = v | (32'(mdl[d][base + i]) << (8 * i));
      if (!f[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      q = v;
    end
  endtask

  task automatic check_resp(input int d, input logic e, input logic [31:0] data);
    exp_t x;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_ready dut=%0d got err=%0b data=%08h required no response", d, e, data);
    end else begin
      x = exp_q.pop_front();
      if (x.dut != d || x.err !== e || x.data !== data || (cyc - x.req_cyc) != wait_of[d]) begin
        failures++;
        $display("FAIL resp dut=%0d got err=%0b data=%08h lat=%0d required dut=%0d err=%0b data=%08h lat=%0d",
                 d, e, data, cyc - x.req_cyc, x.dut, x.err, x.data, wait_of[x.dut]);
      end
    end
  endtask

  // Monitor: every ready pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (ready_w2) check_resp(0, err_w2, rdata_w2);
      if (ready_w0) check_resp(1, err_w0, rdata_w0);
    end
  end

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%08h required=%08h", name, got, req);
    end
  endtask

  task automatic do_req(input int d, input logic r, input logic w, input logic [8:0] a,
                        input logic [2:0] f, input logic [31:0] wd);
    logic e;
    logic [31:0] q;
    exp_t x;
    int k;
    @(negedge clk);
    rd_s[d] = r; wr_s[d] = w; addr_s[d] = a; f3_s[d] = f; wdata_s[d] = wd;
    model(d, r, w, a, f, wd, e, q);
    x.dut = d; x.err = e; x.data = q; x.req_cyc = cyc + 1;
    exp_q.push_back(x);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!ready_of(d) && k < 40);
    if (!ready_of(d)) begin
      checks++;
      failures++;
      $display("FAIL timeout dut=%0d got no ready within %0d cycles required ready", d, k);
    end
    rd_s[d] = 1'b0;
    wr_s[d] = 1'b0;
  endtask

  task automatic rand_req(input int d);
    logic [8:0] a;
    logic [2:0] f;
    int sel;
    sel = $urandom_range(0, 9);
    a   = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 63)) : 9'($urandom_range(0, 511));
    if ($urandom_range(0, 3) != 0) a = a & ($urandom_range(0, 1) == 0 ? 9'h1FC : 9'h1FE);
    f   = 3'($urandom_range(0, 7));
    if (sel < 5) do_req(d, 1'b1, 1'b0, a, f, 32'd0);
    else if (sel < 9) do_req(d, 1'b0, 1'b1, a, f, $urandom);
    else do_req(d, 1'b1, 1'b1, a, f, $urandom);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 512; i++) mdl[d][i] = 8'h00;
    end
    rst_s = 2'b11; rd_s = 2'b00; wr_s = 2'b00;
    addr_s = '0; f3_s = '0; wdata_s = '0;
    repeat (3) @(negedge clk);
    rst_s = 2'b00;
    @(negedge clk);
    check_eq("reset_ready_w2", {31'd0, ready_w2}, 32'd0);
    check_eq("reset_err_w2", {31'd0, err_w2}, 32'd0);
    check_eq("reset_rdata_w2", rdata_w2, 32'd0);
    check_eq("reset_ready_w0", {31'd0, ready_w0}, 32'd0);
    check_eq("reset_err_w0", {31'd0, err_w0}, 32'd0);
    check_eq("reset_rdata_w0", rdata_w0, 32'd0);
    mon_en = 1'b1;

    do_req(0, 1'b0, 1'b1, 9'h010, 3'b010, 32'hDEAD_BEEF);
    do_req(0, 1'b1, 1'b0, 9'h010, 3'b010, 32'd0);
    do_req(0, 1'b0, 1'b1, 9'h013, 3'b000, 32'h0000_0080);
    do_req(0, 1'b1, 1'b0, 9'h013, 3'b000, 32'd0);
    do_req(0, 1'b1, 1'b0, 9'h013, 3'b100, 32'd0);
    do_req(0, 1'b1, 1'b0, 9'h010, 3'b010, 32'd0);
    do_req(0, 1'b0, 1'b1, 9'h022, 3'b001, 32'h0000_8001);
    do_req(0, 1'b1, 1'b0, 9'h022, 3'b001, 32'd0);
    do_req(0, 1'b1, 1'b0, 9'h022, 3'b101, 32'd0);
    do_req(0, 1'b1, 1'b0, 9'h020, 3'b010, 32'd0);
    do_req(0, 1'b1, 1'b0, 9'h011, 3'b010, 32'd0);
    do_req(0, 1'b0, 1'b1, 9'h023, 3'b001, 32'hFFFF_FFFF);
    do_req(0, 1'b1, 1'b0, 9'h010, 3'b011, 32'd0);
    do_req(0, 1'b1, 1'b1, 9'h010, 3'b010, 32'h1111_1111);
    do_req(0, 1'b1, 1'b0, 9'h010, 3'b010, 32'd0);

    // Reset during BUSY must abort the store with no ready pulse.
    @(negedge clk);
    rd_s[0] = 1'b0; wr_s[0] = 1'b1; addr_s[0] = 9'h040; f3_s[0] = 3'b010; wdata_s[0] = 32'h1234_5678;
    @(negedge clk);
    rst_s[0] = 1'b1; wr_s[0] = 1'b0;
    @(negedge clk);
    rst_s[0] = 1'b0;
    repeat (5) @(negedge clk);
    do_req(0, 1'b1, 1'b0, 9'h040, 3'b010, 32'd0);

    do_req(1, 1'b0, 1'b1, 9'h1FC, 3'b010, 32'hA5C3_0F71);
    do_req(1, 1'b1, 1'b0, 9'h1FC, 3'b010, 32'd0);
    do_req(1, 1'b1, 1'b0, 9'h1FF, 3'b000, 32'd0);
    do_req(1, 1'b1, 1'b0, 9'h1FE, 3'b101, 32'd0);
    do_req(1, 1'b1, 1'b0, 9'h1FD, 3'b001, 32'd0);

    for (int n = 0; n < 120; n++) rand_req(0);
    for (int n = 0; n < 120; n++) rand_req(1);

    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_responses got=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder at the far end of the core's load/store port (wr, rd, addr, wr_data, rd_data). It holds a byte-addressable 512-byte RAM and serves single load/store requests over a ready handshake with a programmable wait-state count. It performs RV32I byte-lane selection and load sign/zero extension, and flags misaligned or illegal-size accesses.

Parameters:
- DATA_W, 32: data bus width; only 32 is supported.
- ADDR_W, 9: byte-address width; RAM depth is 2**ADDR_W/4 words (128).
- WAIT_CYCLES, 2: extra cycles between request capture and commit; legal range 0..15.

Ports:
- clk, input, 1: system clock; all logic is rising-edge.
- reset, input, 1: synchronous, active-high reset.
- wr, input, 1: store request.
- rd, input, 1: load request.
- addr, input, ADDR_W: byte address.
- funct3, input, 3: access size and signedness, RV32I encoding.
- wr_data, input, DATA_W: store data, right-aligned.
- rd_data, output, DATA_W: load result; valid only when ready=1.
- ready, output, 1: one-cycle pulse marking completion.
- err, output, 1: qualified by ready; marks a misaligned, illegal-funct3 or rd+wr access.

Behaviour:
- Reset, synchronous, active-high:
  - state=IDLE, counter=0, ready=0, err=0, rd_data=0.
  - RAM contents are not cleared by reset. RAM is zero-initialised at time 0.
  - Reset asserted in any state aborts the operation. A store whose commit cycle has not yet occurred is never written.
- States IDLE, BUSY, DONE; one encoding enum.
  - IDLE: when (rd|wr)=1, capture addr, funct3, wr_data, rd, wr.
    - WAIT_CYCLES>0: load counter=WAIT_CYCLES-1 and go to BUSY.
    - WAIT_CYCLES=0: commit this cycle and go to DONE.
  - BUSY: decrement counter. At counter=0, commit and go to DONE.
  - DONE: ready=1 for exactly this cycle, with rd_data and err valid. Then return to IDLE unconditionally.
- Latency: a request sampled at edge N gives ready=1 in cycle N+1+WAIT_CYCLES.
- Handshake:
  - The requester holds rd/wr and the operands stable until ready.
  - Inputs are ignored in BUSY and DONE.
  - rd/wr still high in the IDLE cycle after DONE is a new request. The requester deasserts in that cycle.
- Commit rules on the captured values:
  - Word index = addr[ADDR_W-1:2]. Byte lane = addr[1:0].
  - Store funct3 codes:
    - 000 SB writes lane addr[1:0] with wr_data[7:0].
    - 001 SH writes lanes {addr[1],0} and {addr[1],1} with wr_data[15:0].
    - 010 SW writes all lanes.
  - Load funct3 codes:
    - 000 LB sign-extends the byte.
    - 001 LH sign-extends the halfword.
    - 010 LW returns the word.
    - 100 LBU zero-extends the byte.
    - 101 LHU zero-extends the halfword.
  - Error cases (err=1):
    - halfword access with addr[0]=1
    - word access with addr[1:0]!=0
    - any other funct3
    - rd=1 and wr=1 together
  - On error: no RAM write, rd_data=0.
  - Stores return rd_data=0.
- Storage: the RAM write port and the registered read happen only in the commit cycle. This fits block-RAM inference.
- Address wrap does not arise: the full ADDR_W space is backed.

Decomposition:
- Package dmem_pkg holds:
  - enum state_t {IDLE, BUSY, DONE}
  - funct3 localparams F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101
  - function lane_mask(funct3, addr[1:0]) returning a 4-bit byte enable
  - function load_extend(word, funct3, addr[1:0])
- One sub-module, dmem_bram: a 4-byte-enable, 128x32 single-port RAM with synchronous write and registered read.

Test Plan:
- WAIT_CYCLES=2. SW 0xDEADBEEF @0x010, then LW @0x010 -> each ready arrives 3 cycles after the request; LW gives rd_data=0xDEADBEEF, err=0.
- SB 0x80 @0x013, then LB @0x013 -> rd_data=0xFFFFFF80. LBU @0x013 -> 0x00000080. LW @0x010 -> 0x80ADBEEF.
- SH 0x8001 @0x022, then LH @0x022 -> 0xFFFF8001. LHU -> 0x00008001. LW @0x020 -> 0x80010000.
- LW @0x011, SH @0x023, funct3=011, and rd=wr=1 -> each returns ready with err=1 and rd_data=0. A follow-up LW @0x010 is unchanged.
- Reset pulse during BUSY of SW 0x12345678 @0x040 -> no ready pulse. Later LW @0x040 -> prior contents (0 from init).
- WAIT_CYCLES=0 build: back-to-back requests with rd deasserted for one IDLE cycle -> ready 1 cycle after each request; RAM@0x1FC (top word) SW/LW round-trips correctly.
